mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage of the 8-bit core; sits between the EX/MEM register and the WB stage.
//  Issues loads/stores to the data memory over a req/ack handshake and stalls upstream while
//  an access is in flight. Registers the write-back bundle (MEM/WB) for the WB stage.
//  Memory time-outs are reported as a pipeline exception.
// PARAMETERS
//  TIMEOUT_CYCLES  16  BUSY cycles without mem_ack before the access is abandoned (>=2)
//  CNT_W            5  width of the time-out counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  asynchronous, active-high
//  in_valid      in   1  EX/MEM slot holds a real instruction
//  in_mem_read   in   1  load
//  in_mem_write  in   1  store (in_mem_read & in_mem_write never both high)
//  in_reg_write  in   1  instruction writes Rd
//  in_imm_sel    in   1  write-back data = ImmVal instead of ALUResult (non-load)
//  in_alu_result in   8  ALU result; memory address for loads/stores
//  in_rd_val     in   8  store data
//  in_rd         in   3  destination register
//  in_imm_val    in   8  immediate value
//  in_exp_error  in   1  exception flag from EX
//  stall         out  1  upstream register must hold its contents this cycle
//  mem_req       out  1  memory request, held high until ack or time-out
//  mem_we        out  1  1 = write
//  mem_addr      out  8  address
//  mem_wdata     out  8  write data
//  mem_ack       in   1  request accepted/completed this cycle
//  mem_rdata     in   8  read data, valid with mem_ack on reads
//  wb_valid      out  1  WB bundle valid
//  wb_reg_write  out  1  write enable to register file (0 when wb_valid=0)
//  wb_rd         out  3  destination register
//  wb_data       out  8  write-back data
//  wb_exp_error  out  1  exception flag to WB
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, every output 0 (mem_req drops asynchronously, mid-access too).
//  is_mem = in_valid & (in_mem_read | in_mem_write).
//  Non-memory op (IDLE): WB bundle registered on next edge, latency 1, stall=0.
//   wb_data = in_imm_sel ? in_imm_val : in_alu_result; wb_exp_error = in_exp_error.
//  in_valid=0 in IDLE: next edge wb_valid=0, wb_reg_write=0 (bubble).
//  FSM IDLE->BUSY: in IDLE with is_mem: latch addr/wdata/we/rd/reg_write/exp_error
//   into hold regs, next edge state=BUSY, mem_req=1, counter=0.
//  BUSY: mem_req/mem_we/mem_addr/mem_wdata stable from hold regs; counter increments
//   each cycle without ack. mem_ack high -> next edge: state=IDLE, mem_req=0,
//   wb_valid=1, wb_data = load ? mem_rdata : 8'h00, wb_reg_write = hold reg_write & load,
//   wb_exp_error = hold exp_error.
//  Time-out: in BUSY, counter==TIMEOUT_CYCLES-1 and mem_ack=0 -> next edge: state=IDLE,
//   mem_req=0, wb_valid=1, wb_reg_write=0, wb_data=0, wb_exp_error=1.
//  Simultaneous ack and time-out: ack wins (normal completion).
//  stall = is_mem & ~(state==BUSY & mem_ack) & ~(timeout fires this cycle);
//   thus a memory op stalls from its first IDLE cycle through the cycle before ack.
//  While stalled, WB bundle is a bubble (wb_valid=0, wb_reg_write=0) each cycle.
//  Access latency: ack in Nth BUSY cycle -> wb_valid at edge N+1 after instruction
//   entered (N>=1). Back-to-back memory ops re-enter BUSY after one IDLE cycle.
//  mem_ack in IDLE is ignored. mem_addr/wdata/we = 0 outside BUSY.
// STRUCTURE
//  Defs package: mem_state_t enum {MS_IDLE, MS_BUSY}; MEM_TIMEOUT_DEFAULT = 16.
//  Sub-module mem_txn_ctrl: FSM + time-out counter + hold regs, producing mem_* and
//   done/timeout pulses; mem_access_stage adds stall logic, data mux and WB register.
// TESTING
//  Reset mid-BUSY (mem_req=1) -> mem_req=0 immediately; all wb_* 0; state IDLE.
//  ALU op rd=3, alu=8'h5A, reg_write=1 -> next edge wb_valid=1 wb_rd=3 wb_data=5A, stall=0.
//  Load addr 8'h10, ack on 3rd BUSY cycle with rdata=8'hC3 -> stall 3 cycles, mem_addr=10,
//   wb_data=C3 wb_reg_write=1 one edge after ack.
//  Store addr 8'h20 data 8'h77, immediate ack -> mem_we=1 mem_wdata=77 for 1 cycle,
//   wb_valid=1 wb_reg_write=0.
//  Load, no ack for 16 BUSY cycles -> mem_req drops, wb_exp_error=1, wb_data=0, stall released.
//  Ack on exactly the 16th BUSY cycle -> normal completion, wb_exp_error=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared types and defaults for the MEM pipeline stage.
package mem_access_stage_pkg;
    typedef enum logic {MS_IDLE, MS_BUSY} mem_state_t;
    localparam int MEM_TIMEOUT_DEFAULT = 16;
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [2:0] rd;
        logic [7:0] data;
        logic       exp_error;
    } wb_bundle_t;
endpackage

// File: rtl/mem_txn_ctrl.sv
// mem_txn_ctrl: data-memory transaction FSM with hold registers and time-out counter.
module mem_txn_ctrl
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [2:0] rd,
    input  logic       reg_write,
    input  logic       exp_error,
    input  logic       mem_ack,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       hold_load,
    output logic [2:0] hold_rd,
    output logic       hold_reg_write,
    output logic       hold_exp_error
);
    mem_state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic hold_we;
    logic [7:0] hold_addr, hold_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MS_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == MS_IDLE) state_n = start ? MS_BUSY : MS_IDLE;
        else if (done || timeout) state_n = MS_IDLE;
    end

    // Counter value k means k BUSY cycles have already passed without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            hold_load      <= 1'b0;
            hold_we        <= 1'b0;
            hold_addr      <= '0;
            hold_wdata     <= '0;
            hold_rd        <= '0;
            hold_reg_write <= 1'b0;
            hold_exp_error <= 1'b0;
        end else if (start) begin
            cnt            <= '0;
            hold_load      <= load;
            hold_we        <= we;
            hold_addr      <= addr;
            hold_wdata     <= wdata;
            hold_rd        <= rd;
            hold_reg_write <= reg_write;
            hold_exp_error <= exp_error;
        end else if (busy && !mem_ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign busy      = (state == MS_BUSY);
    assign done      = busy & mem_ack;
    assign timeout   = busy & ~mem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_req   = busy;
    assign mem_we    = busy & hold_we;
    assign mem_addr  = busy ? hold_addr : 8'h00;
    assign mem_wdata = busy ? hold_wdata : 8'h00;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing loads/stores and registering the MEM/WB bundle.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_mem_read,
    input  logic       in_mem_write,
    input  logic       in_reg_write,
    input  logic       in_imm_sel,
    input  logic [7:0] in_alu_result,
    input  logic [7:0] in_rd_val,
    input  logic [2:0] in_rd,
    input  logic [7:0] in_imm_val,
    input  logic       in_exp_error,
    output logic       stall,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       wb_valid,
    output logic       wb_reg_write,
    output logic [2:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       wb_exp_error
);
    logic is_mem, busy, done, timeout;
    logic hold_load, hold_reg_write, hold_exp_error;
    logic [2:0] hold_rd;
    wb_bundle_t wb_n, wb_q;

    assign is_mem = in_valid & (in_mem_read | in_mem_write);
    assign stall  = is_mem & ~done & ~timeout;

    mem_txn_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .start          (is_mem & ~busy),
        .load           (in_mem_read),
        .we             (in_mem_write),
        .addr           (in_alu_result),
        .wdata          (in_rd_val),
        .rd             (in_rd),
        .reg_write      (in_reg_write),
        .exp_error      (in_exp_error),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .hold_load      (hold_load),
        .hold_rd        (hold_rd),
        .hold_reg_write (hold_reg_write),
        .hold_exp_error (hold_exp_error)
    );

    // Completion and time-out take priority; any other stalled or busy cycle is a bubble.
    always_comb begin
        wb_n = '0;
        if (done) begin
            wb_n.valid     = 1'b1;
            wb_n.reg_write = hold_reg_write & hold_load;
            wb_n.rd        = hold_rd;
            wb_n.data      = hold_load ? mem_rdata : 8'h00;
            wb_n.exp_error = hold_exp_error;
        end else if (timeout) begin
            wb_n.valid     = 1'b1;
            wb_n.rd        = hold_rd;
            wb_n.exp_error = 1'b1;
        end else if (!stall && !busy && in_valid) begin
            wb_n.valid     = 1'b1;
            wb_n.reg_write = in_reg_write;
            wb_n.rd        = in_rd;
            wb_n.data      = in_imm_sel ? in_imm_val : in_alu_result;
            wb_n.exp_error = in_exp_error;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wb_q <= '0;
        else       wb_q <= wb_n;
    end

    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_rd        = wb_q.rd;
    assign wb_data      = wb_q.data;
    assign wb_exp_error = wb_q.exp_error;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for the MEM stage.
module tb_mem_access_stage;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
    logic       in_reg_write = 1'b0, in_imm_sel = 1'b0, in_exp_error = 1'b0;
    logic [7:0] in_alu_result = '0, in_rd_val = '0, in_imm_val = '0;
    logic [2:0] in_rd = '0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic       stall, mem_req, mem_we, wb_valid, wb_reg_write, wb_exp_error;
    logic [7:0] mem_addr, mem_wdata, wb_data;
    logic [2:0] wb_rd;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_imm_sel(in_imm_sel), .in_alu_result(in_alu_result),
        .in_rd_val(in_rd_val), .in_rd(in_rd), .in_imm_val(in_imm_val), .in_exp_error(in_exp_error),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exp_error(wb_exp_error)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
        in_imm_sel = 0; in_exp_error = 0; mem_ack = 0;
    endtask

    task automatic issue_load(input logic [7:0] addr, input logic [2:0] rd);
        in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_reg_write = 1;
        in_alu_result = addr; in_rd = rd; in_exp_error = 0;
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, ".wb_valid"}, 16'(wb_valid), 16'h0);
        check({tag, ".wb_reg_write"}, 16'(wb_reg_write), 16'h0);
        check({tag, ".wb_data"}, 16'(wb_data), 16'h0);
        check({tag, ".wb_exp_error"}, 16'(wb_exp_error), 16'h0);
    endtask

    initial begin
        tick(); tick();
        check("rst.mem_req", 16'(mem_req), 16'h0);
        check("rst.stall", 16'(stall), 16'h0);
        check_wb_zero("rst");
        reset = 0;

        // ALU op, register data
        in_valid = 1; in_reg_write = 1; in_rd = 3'd3; in_alu_result = 8'h5A;
        #1 check("alu.stall", 16'(stall), 16'h0);
        tick();
        check("alu.wb_valid", 16'(wb_valid), 16'h1);
        check("alu.wb_rd", 16'(wb_rd), 16'h3);
        check("alu.wb_data", 16'(wb_data), 16'h5A);
        check("alu.wb_reg_write", 16'(wb_reg_write), 16'h1);

        // immediate select
        in_imm_sel = 1; in_imm_val = 8'h3C; in_rd = 3'd5; in_exp_error = 1;
        tick();
        check("imm.wb_data", 16'(wb_data), 16'h3C);
        check("imm.wb_rd", 16'(wb_rd), 16'h5);
        check("imm.wb_exp_error", 16'(wb_exp_error), 16'h1);

        // bubble, with a stray ack in IDLE that must be ignored
        idle_inputs(); mem_ack = 1;
        tick();
        check("bub.wb_valid", 16'(wb_valid), 16'h0);
        check("bub.wb_reg_write", 16'(wb_reg_write), 16'h0);
        check("bub.mem_req", 16'(mem_req), 16'h0);
        mem_ack = 0;

        // load, ack on third BUSY cycle
        issue_load(8'h10, 3'd2);
        #1 check("ld.stall0", 16'(stall), 16'h1);
        check("ld.req0", 16'(mem_req), 16'h0);
        check("ld.addr0", 16'(mem_addr), 16'h0);
        tick();
        check("ld.req1", 16'(mem_req), 16'h1);
        check("ld.addr1", 16'(mem_addr), 16'h10);
        check("ld.we1", 16'(mem_we), 16'h0);
        check("ld.stall1", 16'(stall), 16'h1);
        check("ld.wb_valid1", 16'(wb_valid), 16'h0);
        tick();
        check("ld.stall2", 16'(stall), 16'h1);
        check("ld.wb_valid2", 16'(wb_valid), 16'h0);
        tick();
        mem_ack = 1; mem_rdata = 8'hC3;
        #1 check("ld.stall3", 16'(stall), 16'h0);
        tick();
        idle_inputs(); mem_rdata = 8'h00;
        check("ld.req_end", 16'(mem_req), 16'h0);
        check("ld.wb_valid", 16'(wb_valid), 16'h1);
        check("ld.wb_data", 16'(wb_data), 16'hC3);
        check("ld.wb_reg_write", 16'(wb_reg_write), 16'h1);
        check("ld.wb_rd", 16'(wb_rd), 16'h2);
        check("ld.wb_exp_error", 16'(wb_exp_error), 16'h0);

        // store, immediate ack
        in_valid = 1; in_mem_write = 1; in_reg_write = 1; in_alu_result = 8'h20; in_rd_val = 8'h77;
        tick();
        check("st.req", 16'(mem_req), 16'h1);
        check("st.we", 16'(mem_we), 16'h1);
        check("st.addr", 16'(mem_addr), 16'h20);
        check("st.wdata", 16'(mem_wdata), 16'h77);
        mem_ack = 1;
        #1 check("st.stall", 16'(stall), 16'h0);
        tick();
        idle_inputs();
        check("st.req_end", 16'(mem_req), 16'h0);
        check("st.we_end", 16'(mem_we), 16'h0);
        check("st.wdata_end", 16'(mem_wdata), 16'h0);
        check("st.wb_valid", 16'(wb_valid), 16'h1);
        check("st.wb_reg_write", 16'(wb_reg_write), 16'h0);
        check("st.wb_data", 16'(wb_data), 16'h0);

        // load with no ack: time-out after 16 BUSY cycles
        issue_load(8'h30, 3'd4); mem_rdata = 8'hEE;
        tick();
        for (int k = 1; k < 16; k++) begin
            check($sformatf("to.stall%0d", k), 16'(stall), 16'h1);
            check($sformatf("to.req%0d", k), 16'(mem_req), 16'h1);
            tick();
        end
        check("to.req16", 16'(mem_req), 16'h1);
        check("to.stall16", 16'(stall), 16'h0);
        tick();
        idle_inputs();
        check("to.req_end", 16'(mem_req), 16'h0);
        check("to.wb_valid", 16'(wb_valid), 16'h1);
        check("to.wb_exp_error", 16'(wb_exp_error), 16'h1);
        check("to.wb_data", 16'(wb_data), 16'h0);
        check("to.wb_reg_write", 16'(wb_reg_write), 16'h0);

        // ack exactly on the 16th BUSY cycle wins over time-out
        issue_load(8'h40, 3'd6);
        tick();
        for (int k = 1; k < 16; k++) tick();
        mem_ack = 1; mem_rdata = 8'hA5;
        #1 check("edge.stall", 16'(stall), 16'h0);
        tick();
        idle_inputs();
        check("edge.wb_valid", 16'(wb_valid), 16'h1);
        check("edge.wb_exp_error", 16'(wb_exp_error), 16'h0);
        check("edge.wb_data", 16'(wb_data), 16'hA5);
        check("edge.wb_reg_write", 16'(wb_reg_write), 16'h1);
        check("edge.req_end", 16'(mem_req), 16'h0);

        // reset while BUSY drops mem_req without a clock edge
        issue_load(8'h50, 3'd1);
        tick();
        check("mrst.req_before", 16'(mem_req), 16'h1);
        #2 reset = 1;
        #1 check("mrst.req", 16'(mem_req), 16'h0);
        check("mrst.addr", 16'(mem_addr), 16'h0);
        check_wb_zero("mrst");
        idle_inputs();
        tick();
        reset = 0;
        tick();
        check("mrst.req_after", 16'(mem_req), 16'h0);
        check("mrst.wb_valid_after", 16'(wb_valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
